// File: rtl/string_engine_avalon.sv
// string_engine_avalon: Avalon-MM string coprocessor. Holds two NUL-terminated
// operand strings (A, B) and a result buffer, and runs LENGTH, COMPARE, TOUPPER,
// CONCAT or FIND through a byte-serial state machine, one byte position per cycle.
module string_engine_avalon #(
    parameter int MAX_BLOCKS   = 8,
    parameter int ADDRESS_BITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    irq
);
    localparam int N  = 4 * MAX_BLOCKS;
    localparam int PW = $clog2(N);
    localparam int WW = $clog2(MAX_BLOCKS);
    localparam logic [31:0] A_BASE = 32'(2);
    localparam logic [31:0] B_BASE = 32'(MAX_BLOCKS + 2);
    localparam logic [31:0] R_BASE = 32'(2 * MAX_BLOCKS + 2);
    localparam logic [31:0] R_END  = 32'(3 * MAX_BLOCKS + 2);
    localparam logic [31:0] ALL1   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN_A, S_RUN_B, S_DONE} state_t;

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
        return 8'(word >> {lane, 3'b000});
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    state_t         r_state, w_next_state;
    logic [31:0]    r_a   [MAX_BLOCKS];
    logic [31:0]    r_b   [MAX_BLOCKS];
    logic [31:0]    r_res [MAX_BLOCKS];
    logic [PW-1:0]  r_p, r_q, w_p_next, w_q_next, w_res_pos;
    logic [2:0]     r_op;
    logic           r_irq_en, r_done;
    logic [31:0]    r_scalar, w_fin_scalar, w_rdata, w_addr;
    logic           w_fin, w_res_we;
    logic [7:0]     w_res_byte, w_a, w_b, w_c;
    logic           w_busy, w_wr_ctrl, w_abort, w_go, w_start, w_bad, w_q_last, w_p_last;
    logic           w_in_a, w_in_b, w_in_r;
    logic [WW-1:0]  w_widx_a, w_widx_b, w_widx_r;

    assign w_addr    = 32'(address);
    assign w_in_a    = (w_addr >= A_BASE) && (w_addr < B_BASE);
    assign w_in_b    = (w_addr >= B_BASE) && (w_addr < R_BASE);
    assign w_in_r    = (w_addr >= R_BASE) && (w_addr < R_END);
    assign w_widx_a  = WW'(w_addr - A_BASE);
    assign w_widx_b  = WW'(w_addr - B_BASE);
    assign w_widx_r  = WW'(w_addr - R_BASE);

    assign w_busy    = (r_state == S_RUN_A) || (r_state == S_RUN_B);
    assign w_wr_ctrl = chipselect && write && (w_addr == 32'd0);
    assign w_abort   = w_wr_ctrl && writedata[6];
    // go is dropped while busy and loses to a simultaneous abort
    assign w_go      = w_wr_ctrl && writedata[1] && !writedata[6] && !w_busy;
    assign w_start   = w_go && (writedata[5:3] <= 3'd4);
    assign w_bad     = w_go && (writedata[5:3] > 3'd4);

    assign w_a       = get_byte(r_a[r_p[PW-1:2]], r_p[1:0]);
    assign w_b       = get_byte(r_b[r_p[PW-1:2]], r_p[1:0]);
    assign w_c       = get_byte(r_b[0], 2'd0);
    assign w_p_last  = (r_p == PW'(N - 1));
    assign w_q_last  = (r_q == PW'(N - 1));
    assign irq       = r_done && r_irq_en;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // next state plus the per-position work of the running operation
    always_comb begin
        w_next_state = r_state;
        w_p_next     = r_p;
        w_q_next     = r_q;
        w_fin        = 1'b0;
        w_fin_scalar = r_scalar;
        w_res_we     = 1'b0;
        w_res_pos    = r_q;
        w_res_byte   = 8'h00;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else if (w_start) begin
            w_next_state = S_RUN_A;
            w_p_next     = '0;
            w_q_next     = '0;
        end else if (w_bad) begin
            w_next_state = S_DONE;
        end else if (r_state == S_RUN_A) begin
            unique case (r_op)
                3'd0: begin
                    if (w_a == 8'h00) begin w_fin = 1'b1; w_fin_scalar = 32'(r_p); end
                    else if (w_p_last) begin w_fin = 1'b1; w_fin_scalar = 32'(N); end
                    else w_p_next = r_p + 1'b1;
                end
                3'd1: begin
                    if (w_a != w_b) begin
                        w_fin = 1'b1;
                        w_fin_scalar = (w_a > w_b) ? 32'd1 : ALL1;
                    end else if (w_a == 8'h00 || w_p_last) begin
                        w_fin = 1'b1; w_fin_scalar = 32'd0;
                    end else w_p_next = r_p + 1'b1;
                end
                3'd2: begin
                    w_res_we   = 1'b1;
                    w_res_pos  = r_p;
                    w_res_byte = to_upper(w_a);
                    if (w_a == 8'h00) begin w_fin = 1'b1; w_fin_scalar = 32'(r_p); end
                    else if (w_p_last) begin w_fin = 1'b1; w_fin_scalar = 32'(N); end
                    else w_p_next = r_p + 1'b1;
                end
                3'd3: begin
                    // NUL of A writes nothing; B starts at the same output index
                    if (w_a == 8'h00) begin
                        w_next_state = S_RUN_B;
                        w_p_next     = '0;
                    end else if (w_q_last) begin
                        w_res_we = 1'b1; w_fin = 1'b1;
                        w_fin_scalar = {1'b1, 31'(N - 1)};
                    end else begin
                        w_res_we   = 1'b1;
                        w_res_byte = w_a;
                        w_p_next   = r_p + 1'b1;
                        w_q_next   = r_q + 1'b1;
                    end
                end
                3'd4: begin
                    if (w_a == w_c) begin w_fin = 1'b1; w_fin_scalar = 32'(r_p); end
                    else if (w_a == 8'h00 || w_p_last) begin w_fin = 1'b1; w_fin_scalar = ALL1; end
                    else w_p_next = r_p + 1'b1;
                end
                default: begin w_fin = 1'b1; w_fin_scalar = ALL1; end
            endcase
        end else if (r_state == S_RUN_B) begin
            // last output slot must hold the terminator; a non-NUL there is overflow
            w_res_we = 1'b1;
            if (w_q_last && w_b != 8'h00) begin
                w_fin = 1'b1;
                w_fin_scalar = {1'b1, 31'(N - 1)};
            end else begin
                w_res_byte = w_b;
                if (w_b == 8'h00) begin w_fin = 1'b1; w_fin_scalar = 32'(r_q); end
                else begin
                    w_p_next = r_p + 1'b1;
                    w_q_next = r_q + 1'b1;
                end
            end
        end
        if (w_fin) w_next_state = S_DONE;
    end

    // CONTROL fields, SCALAR, position counters and the three buffers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p      <= '0;
            r_q      <= '0;
            r_op     <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_scalar <= '0;
            for (int i = 0; i < MAX_BLOCKS; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
        end else begin
            r_p <= w_p_next;
            r_q <= w_q_next;
            if (w_wr_ctrl && !w_busy) begin
                r_op     <= writedata[5:3];
                r_irq_en <= writedata[7];
                if (writedata[0]) r_done <= 1'b0;
            end
            if (w_start) begin
                r_done   <= 1'b0;
                r_scalar <= '0;
                for (int i = 0; i < MAX_BLOCKS; i++) r_res[i] <= '0;
            end else if (w_bad) begin
                r_done   <= 1'b1;
                r_scalar <= ALL1;
            end else if (w_fin) begin
                r_done   <= 1'b1;
                r_scalar <= w_fin_scalar;
            end
            if (w_res_we)
                r_res[w_res_pos[PW-1:2]][{w_res_pos[1:0], 3'b000} +: 8] <= w_res_byte;
            if (chipselect && write && !w_busy && w_in_a) r_a[w_widx_a] <= writedata;
            if (chipselect && write && !w_busy && w_in_b) r_b[w_widx_b] <= writedata;
        end
    end

    // read mux; unmapped addresses read as zero
    always_comb begin
        w_rdata = '0;
        if (w_addr == 32'd0)      w_rdata = {24'h0, r_irq_en, 1'b0, r_op, w_busy, 1'b0, r_done};
        else if (w_addr == 32'd1) w_rdata = r_scalar;
        else if (w_in_a)          w_rdata = r_a[w_widx_a];
        else if (w_in_b)          w_rdata = r_b[w_widx_b];
        else if (w_in_r)          w_rdata = r_res[w_widx_r];
    end

    // registered read data, held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   readdata <= '0;
        else if (chipselect && read) readdata <= w_rdata;
    end
endmodule

// File: tb/tb_string_engine_avalon.sv
// Directed bench for string_engine_avalon with hand-computed expectations.
module tb_string_engine_avalon;
    localparam int MB = 8;
    localparam int AB = 5;
    localparam int RA = 2;
    localparam int RB = MB + 2;
    localparam int RR = 2 * MB + 2;

    logic          clk = 1'b0;
    logic          reset, chipselect, read, write;
    logic [AB-1:0] address;
    logic [31:0]   writedata, readdata;
    logic          irq;
    int            total = 0;
    int            bad = 0;
    logic [31:0]   rd;

    string_engine_avalon #(.MAX_BLOCKS(MB), .ADDRESS_BITS(AB)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = AB'(a); writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = AB'(a);
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic load_str(input int base, input string s);
        logic [31:0] w;
        for (int i = 0; i < MB; i++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < s.len()) w[8*j +: 8] = s[4*i+j];
            bus_write(base + i, w);
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        int n;
        v = '0;
        n = 0;
        while (v[0] !== 1'b1 && n < 200) begin
            bus_read(0, v);
            n++;
        end
        check({tag, "_done"}, 32'(v[0]), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ctrl, input logic [31:0] exp);
        logic [31:0] v;
        bus_write(0, ctrl);
        wait_done(tag);
        bus_read(1, v);
        check(tag, v, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        @(negedge clk); reset = 1'b0;
        bus_read(0, rd); check("rst_ctrl", rd, 32'h0);
        bus_read(1, rd); check("rst_scalar", rd, 32'h0);

        // LENGTH "abc" with irq enabled: done exactly four edges after the go edge
        load_str(RA, "abc");
        bus_read(RA, rd); check("a_word0", rd, 32'h0063_6261);
        bus_write(0, 32'h82);
        repeat (3) @(posedge clk);
        #1 check("len_irq_early", 32'(irq), 32'h0);
        @(posedge clk);
        #1 check("len_irq_on_time", 32'(irq), 32'h1);
        bus_read(1, rd); check("len_abc", rd, 32'd3);
        bus_read(0, rd); check("len_ctrl", rd, 32'h81);
        bus_write(0, 32'h81);
        check("len_irq_w1c", 32'(irq), 32'h0);

        // LENGTH with no NUL
        for (int i = 0; i < MB; i++) bus_write(RA + i, 32'h4141_4141);
        run_op("len_full", 32'h02, 32'd32);

        // COMPARE
        load_str(RA, "abd"); load_str(RB, "abc");
        run_op("cmp_gt", 32'h0A, 32'd1);
        load_str(RA, "abc"); load_str(RB, "abd");
        run_op("cmp_lt", 32'h0A, 32'hFFFF_FFFF);
        load_str(RB, "abc");
        run_op("cmp_eq", 32'h0A, 32'd0);

        // TOUPPER
        load_str(RA, "Hi z!");
        run_op("upper_len", 32'h12, 32'd5);
        bus_read(RR, rd);     check("upper_w0", rd, 32'h5A20_4948);
        bus_read(RR + 1, rd); check("upper_w1", rd, 32'h0000_0021);
        bus_read(RR + 2, rd); check("upper_w2", rd, 32'h0);

        // CONCAT overflow
        load_str(RA, "abcdefghijklmnopqrst");
        load_str(RB, "ABCDEFGHIJKLMNOPQRST");
        run_op("cat_ovf", 32'h1A, 32'h8000_001F);
        bus_read(RR, rd);     check("cat_ovf_w0", rd, 32'h6463_6261);
        bus_read(RR + 5, rd); check("cat_ovf_join", rd, 32'h4443_4241);
        bus_read(RR + 7, rd); check("cat_ovf_last", rd, 32'h004B_4A49);

        // CONCAT short; result must be zero-filled from the previous run
        load_str(RA, "ab"); load_str(RB, "cd");
        run_op("cat_short", 32'h1A, 32'd4);
        bus_read(RR, rd);     check("cat_short_w0", rd, 32'h6463_6261);
        bus_read(RR + 1, rd); check("cat_short_w1", rd, 32'h0);
        bus_read(RR + 7, rd); check("cat_short_w7", rd, 32'h0);

        // FIND
        load_str(RA, "hello"); load_str(RB, "l");
        run_op("find_l", 32'h22, 32'd2);
        load_str(RB, "z");
        run_op("find_z", 32'h22, 32'hFFFF_FFFF);
        load_str(RB, "");
        run_op("find_nul", 32'hA2, 32'd5);
        check("find_irq", 32'(irq), 32'h1);
        bus_write(0, 32'h81);
        check("find_irq_w1c", 32'(irq), 32'h0);

        // reserved op 6
        bus_write(0, 32'h32);
        bus_read(0, rd); check("rsv_ctrl", rd, 32'h31);
        bus_read(1, rd); check("rsv_scalar", rd, 32'hFFFF_FFFF);

        // abort during a 30-byte LENGTH
        load_str(RA, "xxxxxxxxxxxxxxxxxxxxxxxxxxxxxx");
        bus_write(0, 32'h82);
        repeat (5) @(posedge clk);
        bus_write(0, 32'h40);
        bus_read(0, rd); check("abort_ctrl", rd, 32'h80);
        check("abort_irq", 32'(irq), 32'h0);
        repeat (40) @(posedge clk);
        bus_read(0, rd); check("abort_ctrl_later", rd, 32'h80);

        // writes to A while busy are ignored
        bus_write(0, 32'h02);
        bus_write(RA, 32'h0);
        wait_done("busywr");
        bus_read(1, rd);  check("busywr_len", rd, 32'd30);
        bus_read(RA, rd); check("busywr_a0", rd, 32'h7878_7878);

        // async reset in the middle of a run
        bus_write(0, 32'h82);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_readdata", readdata, 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        #3 reset = 1'b0;
        bus_read(0, rd);      check("arst_ctrl", rd, 32'h0);
        bus_read(1, rd);      check("arst_scalar", rd, 32'h0);
        bus_read(RA, rd);     check("arst_a0", rd, 32'h0);
        bus_read(RR, rd);     check("arst_r0", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/string_engine_avalon.md
# string_engine_avalon

Parametrised Avalon-MM string coprocessor for the Nios II system; next generation of the two-string accelerator. It holds two NUL-terminated operand strings and a result buffer. It runs one of five operations (LENGTH, COMPARE, TOUPPER, CONCAT, FIND) through a byte-serial state machine. Completion is reported through a status register and an optional interrupt.

## Interface
- MAX_BLOCKS, 8: 32-bit words per string buffer; capacity N = 4*MAX_BLOCKS bytes.
- ADDRESS_BITS, 5: word-address width; requires 2^ADDRESS_BITS >= 3*MAX_BLOCKS+2.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- address  in  ADDRESS_BITS  word address.
- writedata  in  32  write data.
- readdata  out  32  registered read data; reset 0.
- irq  out  1  done & irq_en; reset 0.

## Operation
- Address map:
  - 0 CONTROL
  - 1 SCALAR result (RO)
  - 2..MAX_BLOCKS+1 StringA
  - MAX_BLOCKS+2..2*MAX_BLOCKS+1 StringB
  - 2*MAX_BLOCKS+2..3*MAX_BLOCKS+1 Result buffer (RO)
  - Unmapped reads return 0; unmapped and RO writes are ignored.
- Byte order: string byte i is word i/4 (relative to buffer base), bits [8*(i%4)+7 : 8*(i%4)] (little-endian).
- CONTROL bits:
  - [0] done: RO; W1C.
  - [1] go: W1, self-clearing, reads 0.
  - [2] busy: RO.
  - [5:3] op.
  - [6] abort: W1, reads 0.
  - [7] irq_en.
  - Other bits read 0.
- op encodings: 0 LENGTH, 1 COMPARE, 2 TOUPPER, 3 CONCAT, 4 FIND; 5-7 reserved.
- FSM states: IDLE, RUN_A, RUN_B (CONCAT second phase only), DONE.
  - IDLE/DONE -> RUN_A on write of go=1 with a valid op. That write also clears done, clears SCALAR, and zero-fills Result.
  - go with a reserved op: done=1 immediately (state DONE), SCALAR=0xFFFFFFFF.
  - RUN_x -> DONE on termination; done=1, busy=0.
  - Any RUN -> IDLE on abort=1: done stays 0; SCALAR and Result contents are undefined.
- Operations; one byte position per RUN cycle, position index p starting at 0:
  - LENGTH: stop at first NUL in A or at p=N-1. SCALAR = index of the NUL, or N if no NUL.
  - COMPARE: unsigned byte compare A[p] vs B[p]. Stop on mismatch, on a shared NUL, or after N bytes. SCALAR = 0 (equal), 1 (A>B), 0xFFFFFFFF (A<B).
  - TOUPPER: Result[p] = A[p]-0x20 when 0x61<=A[p]<=0x7A, else A[p]. Stop after copying the NUL or at p=N-1. SCALAR = length.
  - CONCAT: RUN_A copies A bytes up to its NUL; the NUL-hit cycle writes nothing and enters RUN_B. RUN_B appends B bytes, NUL included.
    - Output index limit is N-1. On overflow, Result[N-1]=0, SCALAR[30:0]=N-1, SCALAR[31]=1.
    - Otherwise SCALAR = total length excluding NUL.
  - FIND: c = B byte 0. SCALAR = first p with A[p]==c, scanning through A's NUL inclusive. If c=0 this returns strlen(A). If not found, SCALAR = 0xFFFFFFFF.
- Bus access while busy:
  - Writes to StringA/StringB are ignored.
  - CONTROL writes: only abort is honoured; go is ignored.
  - Reads of any register are allowed.
- irq is level: deasserts the cycle after the W1C of done or after irq_en is written 0.

## Timing
- Reads: readLatency 1; readdata is valid the cycle after read&chipselect and holds its value otherwise.
- Writes: zero wait states; the register updates at the write edge.
- go write at edge T: first RUN cycle is T+1 (p=0). Terminating at position k: done=1/busy=0 visible at T+k+2.
- CONCAT latency: lenA+1 cycles in RUN_A plus the RUN_B cycles.
- Simultaneous abort+go in one write: abort wins; result is IDLE.
- Simultaneous W1C of done and completion in the same cycle: completion wins; done=1.
- Reset asserted mid-operation: immediately IDLE; all buffers, SCALAR, CONTROL, readdata and irq go to 0.

## Test plan
- LENGTH: A="abc" (word2=0x00636261), go op=0 at T -> done at T+5, SCALAR=3. Repeat with A full of 0x41 (no NUL) -> SCALAR=32.
- COMPARE: A="abd", B="abc" -> SCALAR=1. Swap operands -> 0xFFFFFFFF. Identical strings -> 0.
- TOUPPER: A="Hi z!" -> Result words 0x5A204948, 0x00000021, rest 0, SCALAR=5.
- CONCAT: A of 20 bytes, B of 20 bytes (N=32) -> SCALAR=0x8000001F, Result byte 31 = 0. With A="ab", B="cd" -> "abcd", SCALAR=4.
- FIND: A="hello", B="l" -> 2. B="z" -> 0xFFFFFFFF. B="" -> 5. irq_en=1 -> irq high with done; W1C drops irq the next cycle.
- Abort and reset: abort during a 30-byte LENGTH -> busy=0, done=0, irq=0. Async reset pulse mid-run -> all reads return 0. Writes to A while busy leave A unchanged. Reserved op 6 -> done immediately, SCALAR=0xFFFFFFFF.
